// File: rtl/popcount_accum_if.sv
// Handshake bundle for popcount_accum: word-in valid/ready and result-out valid/ready.
// The master modport is the producer/consumer side; the slave modport is the counter.
interface popcount_accum_if #(
    parameter int WIDTH = 16
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    out_count;
    logic             out_parity;
    logic             out_all;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_count, out_parity, out_all
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_count, out_parity, out_all
    );
endinterface

// File: rtl/popcount_accum.sv
// Multi-cycle population counter: CHUNK bits per clock through a one-hot decoder.
// Optional macro POPCOUNT_EARLY_EXIT_EN finishes as soon as the remaining word is zero.
module popcount_accum #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic             clk,
    input logic             rst,
    popcount_accum_if.slave bus_io
);
    localparam int NCH   = WIDTH / CHUNK;
    localparam int CW    = $clog2(WIDTH + 1);
    localparam int CCW   = $clog2(CHUNK + 1);
    localparam int IW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int LINES = 2 ** CHUNK;

    if ((WIDTH % CHUNK) != 0 || CHUNK < 1 || CHUNK > 8) begin : gBadParams
        $error("popcount_accum: WIDTH must be a multiple of CHUNK and CHUNK must be 1..8");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] shiftReg_q;
    logic [CW-1:0]    acc_q;
    logic [IW-1:0]    idx_q;
    logic [CW-1:0]    count_q;
    logic             parity_q;
    logic             all_q;

    logic [LINES-1:0] dec;
    logic [CCW-1:0]   chunkCnt;
    logic [CW-1:0]    acc_d;
    logic [WIDTH-1:0] shiftReg_d;
    logic             lastChunk;

    // True when decoder line 'line' contributes to count bit 'bitPos'.
    function automatic logic lineHasBit(input int line, input int bitPos);
        int ones;
        ones = 0;
        for (int k = 0; k < CHUNK; k++) begin
            ones += (line >> k) & 1;
        end
        return ((ones >> bitPos) & 1) != 0;
    endfunction

    always_comb begin
        dec = '0;
        dec[shiftReg_q[CHUNK-1:0]] = 1'b1;
        chunkCnt = '0;
        for (int j = 0; j < LINES; j++) begin
            for (int b = 0; b < CCW; b++) begin
                if (lineHasBit(j, b)) begin
                    chunkCnt[b] = chunkCnt[b] | dec[j];
                end
            end
        end
    end

    assign acc_d      = acc_q + CW'(chunkCnt);
    assign shiftReg_d = shiftReg_q >> CHUNK;

`ifdef POPCOUNT_EARLY_EXIT_EN
    // Once the unprocessed bits are all zero the sum cannot change any more.
    assign lastChunk = (idx_q == IW'(NCH - 1)) || (shiftReg_d == '0);
`else
    assign lastChunk = (idx_q == IW'(NCH - 1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            count_q    <= '0;
            parity_q   <= 1'b0;
            all_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus_io.in_valid) begin
                        shiftReg_q <= bus_io.in_data;
                        acc_q      <= '0;
                        idx_q      <= '0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    acc_q      <= acc_d;
                    shiftReg_q <= shiftReg_d;
                    idx_q      <= idx_q + IW'(1);
                    if (lastChunk) begin
                        count_q  <= acc_d;
                        parity_q <= acc_d[0];
                        all_q    <= (acc_d == CW'(WIDTH));
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    if (bus_io.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_io.in_ready   = (state_q == IDLE);
    assign bus_io.out_valid  = (state_q == DONE);
    assign bus_io.out_count  = count_q;
    assign bus_io.out_parity = parity_q;
    assign bus_io.out_all    = all_q;
endmodule

// File: tb/tb_popcount_accum.sv
// Directed and randomised bench for popcount_accum at WIDTH=16/CHUNK=4 and WIDTH=12/CHUNK=3.
module tb_popcount_accum;
    logic clk;
    logic rst;

    popcount_accum_if #(.WIDTH(16)) bus16 ();
    popcount_accum_if #(.WIDTH(12)) bus12 ();

    popcount_accum #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus16)
    );

    popcount_accum #(.WIDTH(12), .CHUNK(3)) dut12 (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int testsRun = 0;
    int testsFailed = 0;

    typedef struct {
        logic [15:0] data;
        int          expCount;
        int          expParity;
        int          expAll;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Expected edges from accept to out_valid for a word split into nch chunks of chunk bits.
    function automatic int expLatency(input logic [15:0] data, input int chunk, input int nch);
`ifdef POPCOUNT_EARLY_EXIT_EN
        int hi;
        logic [15:0] mask;
        hi = 0;
        mask = 16'((1 << chunk) - 1);
        for (int c = 0; c < nch; c++) begin
            if (((data >> (chunk * c)) & mask) != 16'd0) hi = c;
        end
        return hi + 1;
`else
        if (data == 16'hFFFF && chunk == 0) return 0;
        return nch;
`endif
    endfunction

    task automatic applyStimulus(input logic [15:0] data, output int lat);
        int waitCnt;
        waitCnt = 0;
        while (bus16.in_ready !== 1'b1 && waitCnt < 20) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        checkOutput("in_ready before send", 32'(bus16.in_ready), 32'd1);
        bus16.in_data  = data;
        bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        lat = 0;
        while (bus16.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic applyStimulus12(input logic [11:0] data, output int lat);
        int waitCnt;
        waitCnt = 0;
        while (bus12.in_ready !== 1'b1 && waitCnt < 20) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        bus12.in_data  = data;
        bus12.in_valid = 1'b1;
        @(posedge clk); #1;
        bus12.in_valid = 1'b0;
        lat = 0;
        while (bus12.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume16();
        bus16.out_ready = 1'b1;
        @(posedge clk); #1;
        bus16.out_ready = 1'b0;
        checkOutput("out_valid after consume", 32'(bus16.out_valid), 32'd0);
        checkOutput("in_ready after consume", 32'(bus16.in_ready), 32'd1);
    endtask

    task automatic consume12();
        bus12.out_ready = 1'b1;
        @(posedge clk); #1;
        bus12.out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int expCnt;
        logic [11:0] w12;
        logic sawValid;

        vecs[0] = '{16'hFFFF, 16, 0, 1};
        vecs[1] = '{16'h8001,  2, 0, 0};
        vecs[2] = '{16'h0007,  3, 1, 0};
        vecs[3] = '{16'h0001,  1, 1, 0};
        vecs[4] = '{16'hF0F0,  8, 0, 0};
        vecs[5] = '{16'h0000,  0, 0, 0};
        vecs[6] = '{16'h1248,  4, 0, 0};
        vecs[7] = '{16'h7FFF, 15, 1, 0};

        rst = 1'b1;
        bus16.in_valid = 1'b0; bus16.in_data = '0; bus16.out_ready = 1'b0;
        bus12.in_valid = 1'b0; bus12.in_data = '0; bus12.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset in_ready", 32'(bus16.in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(bus16.out_valid), 32'd0);
        checkOutput("reset out_count", 32'(bus16.out_count), 32'd0);
        checkOutput("reset out_parity", 32'(bus16.out_parity), 32'd0);
        checkOutput("reset out_all", 32'(bus16.out_all), 32'd0);
        checkOutput("reset in_ready w12", 32'(bus12.in_ready), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].data, lat);
            checkOutput($sformatf("latency %h", vecs[i].data), 32'(lat), 32'(expLatency(vecs[i].data, 4, 4)));
            checkOutput($sformatf("count %h", vecs[i].data), 32'(bus16.out_count), 32'(vecs[i].expCount));
            checkOutput($sformatf("parity %h", vecs[i].data), 32'(bus16.out_parity), 32'(vecs[i].expParity));
            checkOutput($sformatf("all %h", vecs[i].data), 32'(bus16.out_all), 32'(vecs[i].expAll));
            consume16();
            checkOutput($sformatf("count held %h", vecs[i].data), 32'(bus16.out_count), 32'(vecs[i].expCount));
        end

        // Backpressure: result must hold and new words must be refused.
        applyStimulus(16'hF0F0, lat);
        for (int c = 0; c < 5; c++) begin
            bus16.in_valid = (c % 2 == 0);
            bus16.in_data  = 16'h0001;
            @(posedge clk); #1;
            checkOutput("bp out_valid", 32'(bus16.out_valid), 32'd1);
            checkOutput("bp out_count", 32'(bus16.out_count), 32'd8);
            checkOutput("bp in_ready", 32'(bus16.in_ready), 32'd0);
        end
        bus16.in_valid = 1'b0;
        consume16();
        @(posedge clk); #1;
        checkOutput("bp no spurious word", 32'(bus16.in_ready), 32'd1);

        // out_ready already high while the word is still being counted.
        bus16.out_ready = 1'b1;
        applyStimulus(16'h00F3, lat);
        checkOutput("early ready out_valid", 32'(bus16.out_valid), 32'd1);
        checkOutput("early ready count", 32'(bus16.out_count), 32'd6);
        @(posedge clk); #1;
        bus16.out_ready = 1'b0;
        checkOutput("early ready back idle", 32'(bus16.in_ready), 32'd1);

        // Reset two cycles into RUN of an all-ones word, with a non-zero prior result.
        applyStimulus(16'h7FFF, lat);
        consume16();
        bus16.in_data  = 16'hFFFF;
        bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("mid-run rst in_ready", 32'(bus16.in_ready), 32'd1);
        checkOutput("mid-run rst out_valid", 32'(bus16.out_valid), 32'd0);
        checkOutput("mid-run rst count", 32'(bus16.out_count), 32'd0);
        checkOutput("mid-run rst parity", 32'(bus16.out_parity), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        sawValid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus16.out_valid !== 1'b0) sawValid = 1'b1;
        end
        checkOutput("no result after rst", 32'(sawValid), 32'd0);
        applyStimulus(16'h0F00, lat);
        checkOutput("post-rst count", 32'(bus16.out_count), 32'd4);
        checkOutput("post-rst latency", 32'(lat), 32'(expLatency(16'h0F00, 4, 4)));
        consume16();

        applyStimulus12(12'hFFF, lat);
        checkOutput("w12 FFF latency", 32'(lat), 32'd4);
        checkOutput("w12 FFF count", 32'(bus12.out_count), 32'd12);
        checkOutput("w12 FFF all", 32'(bus12.out_all), 32'd1);
        consume12();

        for (int n = 0; n < 1000; n++) begin
            w12 = 12'($urandom_range(0, 4095));
            expCnt = $countones(w12);
            applyStimulus12(w12, lat);
            checkOutput($sformatf("w12 latency %h", w12), 32'(lat), 32'(expLatency({4'h0, w12}, 3, 4)));
            checkOutput($sformatf("w12 count %h", w12), 32'(bus12.out_count), 32'(expCnt));
            checkOutput($sformatf("w12 parity %h", w12), 32'(bus12.out_parity), 32'(expCnt % 2));
            checkOutput($sformatf("w12 all %h", w12), 32'(bus12.out_all), 32'(expCnt == 12));
            consume12();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
